// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS memory side: state encoding,
// default widths and the instruction-fetch burst length.
package mips_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_AW    = 8;
  localparam int BURST_LEN = 4;
  localparam int CNT_W     = 4;
  localparam int BEAT_W    = $clog2(BURST_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } state_t;
endpackage

// File: rtl/byte_ram.sv
// Byte storage: synchronous write, asynchronous read, deliberately unreset.
module byte_ram #(
  parameter int WIDTH = 8,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    adr,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd
);
  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[adr] <= wd;

  assign rd = mem[adr];
endmodule

// File: rtl/mem_responder.sv
// Memory slave for the multicycle core: single-byte load/store and 4-beat
// fetch bursts, answered after WAIT programmable wait states.
module mem_responder
  import mips_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW,
  parameter int WAIT  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             we,
  input  logic             burst,
  input  logic [AW-1:0]    adr,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd,
  output logic             ready,
  output logic             busy
);
  localparam logic [CNT_W-1:0]  WAIT_C    = CNT_W'(WAIT);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam bit                NO_WAIT   = (WAIT == 0);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [BEAT_W-1:0] beat;
  logic              we_q, burst_q;
  logic [AW-1:0]     adr_q;
  logic [WIDTH-1:0]  wd_q;

  logic              ram_we;
  logic [AW-1:0]     ram_adr;
  logic [WIDTH-1:0]  ram_wd, ram_rd;
  logic              enter_idle, enter_wait, next_beat;

  assign enter_idle = (state == ST_IDLE) && req && NO_WAIT;
  assign enter_wait = (state == ST_WAIT) && (cnt == CNT_W'(1));
  assign next_beat  = (state == ST_DATA) && burst_q && (beat != LAST_BEAT);

  // The array is accessed on the edge that enters DATA; with no wait states
  // that edge is the capture edge, so the live request is used instead.
  always_comb begin
    ram_we  = 1'b0;
    ram_wd  = wd_q;
    ram_adr = adr_q + AW'(beat);
    if (enter_idle) begin
      ram_we  = we;
      ram_wd  = wd;
      ram_adr = adr;
    end else if (enter_wait) begin
      ram_we  = we_q;
    end else if (next_beat) begin
      ram_adr = adr_q + AW'(beat) + AW'(1);
    end
  end

  byte_ram #(.WIDTH(WIDTH), .AW(AW)) u_ram (
    .clk (clk),
    .we  (ram_we),
    .adr (ram_adr),
    .wd  (ram_wd),
    .rd  (ram_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      ready   <= 1'b0;
      busy    <= 1'b0;
      rd      <= '0;
      cnt     <= '0;
      beat    <= '0;
      we_q    <= 1'b0;
      burst_q <= 1'b0;
      adr_q   <= '0;
      wd_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req) begin
          we_q    <= we;
          burst_q <= burst & ~we;
          adr_q   <= adr;
          wd_q    <= wd;
          cnt     <= WAIT_C;
          beat    <= '0;
          busy    <= 1'b1;
          if (NO_WAIT) begin
            state <= ST_DATA;
            ready <= 1'b1;
            if (!we) rd <= ram_rd;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: if (cnt == CNT_W'(1)) begin
          state <= ST_DATA;
          ready <= 1'b1;
          if (!we_q) rd <= ram_rd;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
        ST_DATA: if (next_beat) begin
          beat <= beat + BEAT_W'(1);
          rd   <= ram_rd;
        end else begin
          state <= ST_IDLE;
          ready <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Bench: one responder with WAIT=2 and one with WAIT=0, driven by a directed
// table, hand-written reset/abort sequences and random traffic.
module tb_mem_responder;
  logic       clk = 1'b0;
  logic       reset;
  logic       req [2];
  logic       we [2];
  logic       burst [2];
  logic [7:0] adr [2];
  logic [7:0] wd [2];
  logic [7:0] rd [2];
  logic       ready [2];
  logic       busy [2];

  int ncmp = 0;
  int nerr = 0;

  logic [7:0] mm [2][256];
  bit         mv [2][256];

  always #5 clk = ~clk;

  mem_responder #(.WIDTH(8), .AW(8), .WAIT(2)) u_dut (
    .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .burst(burst[0]),
    .adr(adr[0]), .wd(wd[0]), .rd(rd[0]), .ready(ready[0]), .busy(busy[0]));

  mem_responder #(.WIDTH(8), .AW(8), .WAIT(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .burst(burst[1]),
    .adr(adr[1]), .wd(wd[1]), .rd(rd[1]), .ready(ready[1]), .busy(busy[1]));

  typedef struct {
    int         d;
    bit         w;
    bit         b;
    logic [7:0] a;
    logic [7:0] dat;
    bit         inj;
    logic [7:0] e0, e1, e2, e3;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction: expected ready/busy/rd per cycle from the latency rules.
  task automatic txn(input int d, input bit w, input bit b, input logic [7:0] a,
                     input logic [7:0] dat, input bit inj,
                     input logic [7:0] e0, input logic [7:0] e1,
                     input logic [7:0] e2, input logic [7:0] e3);
    int lat;
    int nb;
    logic [7:0] e [4];
    lat = (d == 0) ? 3 : 1;
    nb  = (b && !w) ? 4 : 1;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    req[d] = 1'b1; we[d] = w; burst[d] = b; adr[d] = a; wd[d] = dat;
    tick();
    req[d] = 1'b0;
    for (int k = 1; k <= lat + nb; k++) begin
      chk($sformatf("ready d%0d k%0d", d, k), 32'(ready[d]), 32'(k >= lat && k < lat + nb));
      chk($sformatf("busy d%0d k%0d", d, k), 32'(busy[d]), 32'(k < lat + nb));
      if (!w && k >= lat && k < lat + nb)
        chk($sformatf("rd d%0d a%0h beat%0d", d, a, k - lat), 32'(rd[d]), 32'(e[k - lat]));
      if (inj && (k == 1 || k == lat + nb - 1)) begin
        req[d] = 1'b1; we[d] = 1'b1; burst[d] = 1'b0; adr[d] = a; wd[d] = ~dat;
      end
      if (k < lat + nb) begin
        tick();
        req[d] = 1'b0;
      end
    end
    if (w) begin
      mm[d][a] = dat;
      mv[d][a] = 1'b1;
    end
  endtask

  vec_t tbl [$];

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 0; we[d] = 0; burst[d] = 0; adr[d] = 0; wd[d] = 0;
      for (int i = 0; i < 256; i++) mv[d][i] = 1'b0;
    end
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset ready", 32'(ready[d]), 0);
      chk("reset busy", 32'(busy[d]), 0);
      chk("reset rd", 32'(rd[d]), 0);
    end
    tick(); tick();
    reset = 1'b1;
    tick();

    tbl = '{
      '{0, 1, 0, 8'h10, 8'hA5, 0, 0, 0, 0, 0},
      '{0, 0, 0, 8'h10, 8'h00, 0, 8'hA5, 0, 0, 0},
      '{0, 1, 0, 8'hFE, 8'h11, 0, 0, 0, 0, 0},
      '{0, 1, 0, 8'hFF, 8'h22, 0, 0, 0, 0, 0},
      '{0, 1, 0, 8'h00, 8'h33, 0, 0, 0, 0, 0},
      '{0, 1, 0, 8'h01, 8'h44, 0, 0, 0, 0, 0},
      '{0, 0, 1, 8'hFE, 8'h00, 0, 8'h11, 8'h22, 8'h33, 8'h44},
      '{0, 1, 0, 8'h31, 8'hC3, 0, 0, 0, 0, 0},
      '{0, 1, 0, 8'h32, 8'hD4, 0, 0, 0, 0, 0},
      '{0, 1, 0, 8'h33, 8'hE5, 0, 0, 0, 0, 0},
      '{0, 1, 1, 8'h30, 8'h77, 0, 0, 0, 0, 0},
      '{0, 0, 1, 8'h30, 8'h00, 0, 8'h77, 8'hC3, 8'hD4, 8'hE5},
      '{0, 0, 0, 8'h10, 8'h5F, 1, 8'hA5, 0, 0, 0},
      '{0, 0, 0, 8'h10, 8'h00, 0, 8'hA5, 0, 0, 0},
      '{0, 1, 0, 8'h20, 8'hA5, 0, 0, 0, 0, 0},
      '{1, 1, 0, 8'h10, 8'h5C, 0, 0, 0, 0, 0},
      '{1, 0, 0, 8'h10, 8'h00, 0, 8'h5C, 0, 0, 0},
      '{1, 0, 0, 8'h10, 8'h3B, 1, 8'h5C, 0, 0, 0},
      '{1, 0, 0, 8'h10, 8'h00, 0, 8'h5C, 0, 0, 0}
    };
    foreach (tbl[i])
      txn(tbl[i].d, tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].dat, tbl[i].inj,
          tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].e3);

    // Reset in the middle of a burst, then a normal load.
    req[0] = 1'b1; we[0] = 1'b0; burst[0] = 1'b1; adr[0] = 8'hFE;
    tick();
    req[0] = 1'b0;
    tick(); tick(); tick();
    chk("midburst ready before reset", 32'(ready[0]), 1);
    reset = 1'b0;
    #1;
    chk("midburst reset ready", 32'(ready[0]), 0);
    chk("midburst reset busy", 32'(busy[0]), 0);
    chk("midburst reset rd", 32'(rd[0]), 0);
    tick();
    reset = 1'b1;
    tick();
    txn(0, 0, 0, 8'h10, 8'h00, 0, 8'hA5, 0, 0, 0);

    // Store aborted during WAIT must leave the old byte in place.
    req[0] = 1'b1; we[0] = 1'b1; burst[0] = 1'b0; adr[0] = 8'h20; wd[0] = 8'h5A;
    tick();
    req[0] = 1'b0;
    chk("abort busy in wait", 32'(busy[0]), 1);
    reset = 1'b0;
    #1;
    chk("abort busy after reset", 32'(busy[0]), 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    txn(0, 0, 0, 8'h20, 8'h00, 0, 8'hA5, 0, 0, 0);

    // Random traffic against the byte-array model.
    for (int n = 0; n < 60; n++) begin
      int d;
      bit w, b, inj, ok;
      logic [7:0] a, dat, t;
      logic [7:0] e [4];
      d   = int'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      b   = 1'($urandom_range(0, 1));
      inj = ($urandom_range(0, 7) == 0);
      a   = 8'($urandom_range(0, 15)) + 8'hF8;
      dat = 8'($urandom);
      ok  = 1'b1;
      for (int i = 0; i < 4; i++) begin
        t = a + 8'(i);
        e[i] = mm[d][t];
        if ((i == 0 || b) && !mv[d][t]) ok = 1'b0;
      end
      if (!w && !ok) w = 1'b1;
      txn(d, w, b, a, dat, inj, e[0], e[1], e[2], e[3]);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared %0d", ncmp);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Byte-wide memory responder for the multicycle MIPS core: it is the slave end of the core's memory request interface. It accepts single-byte load/store requests and 4-byte instruction-fetch bursts, and inserts a programmable number of wait states before answering. Each completed beat is signalled with a one-cycle `ready` pulse. It sits between the core's datapath/controller and on-chip storage, so the controller can be exercised against realistic memory latency.

## Interface
- `WIDTH`, 8: data width in bits.
- `AW`, 8: address width; depth is 2^AW bytes.
- `WAIT`, 2: wait states inserted before the first beat; legal range 0..15.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low (asserted when 0).
- `req`  in  1  single-cycle request pulse; sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load/fetch; sampled with `req`.
- `burst`  in  1  1 = 4-byte fetch burst (loads only); sampled with `req`.
- `adr`  in  AW  byte address; sampled with `req`.
- `wd`  in  WIDTH  store data; sampled with `req`.
- `rd`  out  WIDTH  registered read data; valid while `ready` = 1.
- `ready`  out  1  beat complete; 1 for exactly one cycle per beat.
- `busy`  out  1  1 whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, WAIT, DATA.
- **IDLE**
  - On `req` = 1, capture `we`, `burst`, `adr` and `wd`. Set `cnt` <= WAIT and `beat` <= 0.
  - Go to WAIT if WAIT > 0, otherwise go straight to DATA.
- **WAIT**
  - If `cnt` == 1: go to DATA. Otherwise `cnt` <= `cnt` − 1.
- **Memory access on entry to DATA**
  - Store: write `wd_q` to `mem[adr_q]`. `rd` keeps its previous value.
  - Load: `rd` <= `mem[adr_q + beat]`.
  - For WAIT = 0, the access uses the live inputs directly.
- **DATA**
  - `ready` = 1.
  - If this is a burst and `beat` < 3: `beat` <= `beat` + 1, `rd` <= `mem[adr_q + beat + 1]`, and stay in DATA.
  - Otherwise go to IDLE.
- Burst address arithmetic is modulo 2^AW: addresses wrap from 2^AW − 1 to 0.
- `burst` = 1 together with `we` = 1 is executed as a single store; the `burst` bit is ignored.
- `req` pulses while `busy` = 1 are dropped: no queuing, no error.
- A `req` in the same cycle that DATA exits to IDLE is also dropped. The earliest accepted new request is the cycle after `ready` falls.
- Storage is not reset. Contents are preserved across reset.

## Timing
- **Reset values:** state = IDLE, `ready` = 0, `busy` = 0, `rd` = 0, `cnt` = 0, `beat` = 0.
- **Single-beat latency:** `ready` is high in cycle N + WAIT + 1 when `req` is sampled in cycle N.
  - WAIT = 2: request in cycle 0, `ready` in cycle 3.
- **Burst:** `ready` is high in cycles N + WAIT + 1 through N + WAIT + 4 continuously, with no gaps.
- **`busy`:** rises in cycle N + 1 and falls the cycle after the last `ready`.
- **Store visibility:** a load accepted after a store's `ready` reads the new data.
- **Reset mid-operation:** asserting reset during WAIT aborts the access. A pending store is not committed. Outputs return to reset values asynchronously.
- **Reset during DATA:** the store has already been committed on entry to DATA. Any remaining burst beats are abandoned.

## Structure
- Shared package `mips_pkg`:
  - state encoding constants IDLE/WAIT/DATA;
  - default WIDTH and AW;
  - the burst length constant BURST_LEN = 4, which matches the 4-byte instruction fetch.
- One sub-module, `byte_ram`, parameterised by WIDTH and AW: synchronous write, asynchronous read, no reset.
- `mem_responder` holds the FSM, the request capture registers, `cnt`, `beat` and the `rd` register.

## Test plan
- **Reset:** drive reset = 0 mid-burst → `ready` = 0, `busy` = 0, `rd` = 0 immediately. After release, the next `req` is accepted normally.
- **Store/load, WAIT = 2:**
  - store 8'hA5 to 8'h10 → `ready` in cycle 3, `busy` = 1 in cycles 1–3;
  - then load from 8'h10 → `rd` = 8'hA5 with `ready` 3 cycles after `req`.
- **Fetch burst with wrap, WAIT = 2:**
  - preload 8'hFE = 8'h11, 8'hFF = 8'h22, 8'h00 = 8'h33, 8'h01 = 8'h44;
  - burst load at 8'hFE → `rd` = 11, 22, 33, 44 on 4 consecutive `ready` cycles (cycles 3–6).
- **WAIT = 0:** load at 8'h10 → `ready` in the cycle after `req`. A back-to-back request issued the cycle after `ready` falls is accepted.
- **Dropped requests:**
  - `req` pulsed during WAIT and during the DATA exit cycle → no extra `ready`, memory unchanged;
  - `burst` = 1 with `we` = 1 → exactly one `ready` and one byte written.
- **Abort:** reset asserted during WAIT of a store of 8'h5A to 8'h20 (old value 8'hA5) → subsequent load from 8'h20 returns 8'hA5.
